// File: rtl/fpu_pkg.sv
// Shared FPU compare definitions: op encodings, the order-preserving key
// transform and NaN classification helpers.
package fpu_pkg;

  typedef enum logic [1:0] {
    FOP_FEQ = 2'b00,
    FOP_FLT = 2'b01,
    FOP_FLE = 2'b10,
    FOP_RSV = 2'b11
  } fop_e;

  localparam logic [31:0] KEY_ZERO = 32'h8000_0000;

  // Maps an IEEE-754 single onto an unsigned key whose integer order matches
  // the numeric order; both zeros collapse onto the same key.
  function automatic logic [31:0] f2key(input logic [31:0] x);
    if (x[30:0] == 31'd0) begin
      return KEY_ZERO;
    end else if (!x[31]) begin
      return {1'b1, x[30:0]};
    end else begin
      return {1'b0, ~x[30:0]};
    end
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_snan(input logic [31:0] x);
    return is_nan(x) && !x[22];
  endfunction

endpackage

// File: rtl/fcmp_key.sv
// Combinational operand conditioner: key transform plus NaN flags when the
// FCMP_NAN_EN macro is defined.
module fcmp_key
  import fpu_pkg::*;
(
  input  logic [31:0] x_i,
  output logic [31:0] key_o
`ifdef FCMP_NAN_EN
  ,
  output logic        nan_o,
  output logic        snan_o
`endif
);

  assign key_o = f2key(x_i);

`ifdef FCMP_NAN_EN
  assign nan_o  = is_nan(x_i);
  assign snan_o = is_snan(x_i);
`endif

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage pipelined FEQ/FLT/FLE compare with valid/ready on both sides.
// Define FCMP_NAN_EN to enable NaN detection and the invalid-operation flag.
module fcmp_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_nv
);

  logic s2_adv;
  logic s1_adv;

  logic [31:0] key1_d;
  logic [31:0] key2_d;

  logic             s1_valid_q;
  fop_e             s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [31:0]      s1_key1_q;
  logic [31:0]      s1_key2_q;

  logic             res_d;
  logic             out_valid_q;
  logic             out_y_q;
  logic [TAG_W-1:0] out_tag_q;

`ifdef FCMP_NAN_EN
  logic nan1_d, snan1_d, nan2_d, snan2_d;
  logic s1_nan1_q, s1_snan1_q, s1_nan2_q, s1_snan2_q;
  logic nv_d;
  logic out_nv_q;
`endif

  fcmp_key u_key1 (
    .x_i   (in_x1),
    .key_o (key1_d)
`ifdef FCMP_NAN_EN
    ,
    .nan_o (nan1_d),
    .snan_o(snan1_d)
`endif
  );

  fcmp_key u_key2 (
    .x_i   (in_x2),
    .key_o (key2_d)
`ifdef FCMP_NAN_EN
    ,
    .nan_o (nan2_d),
    .snan_o(snan2_d)
`endif
  );

  // A stage advances when it is empty or its consumer is taking its contents.
  assign s2_adv   = ~out_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
    end
  end

  // NOTE: payload registers have no reset; s1_valid_q qualifies them.
  always_ff @(posedge clk) begin
    if (s1_adv) begin
      s1_op_q    <= fop_e'(in_op);
      s1_tag_q   <= in_tag;
      s1_key1_q  <= key1_d;
      s1_key2_q  <= key2_d;
`ifdef FCMP_NAN_EN
      s1_nan1_q  <= nan1_d;
      s1_snan1_q <= snan1_d;
      s1_nan2_q  <= nan2_d;
      s1_snan2_q <= snan2_d;
`endif
    end
  end

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    res_d = 1'b0;
`ifdef FCMP_NAN_EN
    nv_d  = 1'b0;
`endif
    case (s1_op_q)
      FOP_FEQ: res_d = (s1_key1_q == s1_key2_q);
      FOP_FLT: res_d = (s1_key1_q <  s1_key2_q);
      FOP_FLE: res_d = (s1_key1_q <= s1_key2_q);
      default: res_d = 1'b0;
    endcase
`ifdef FCMP_NAN_EN
    // Unordered operands: never true; FEQ only signals on a signalling NaN.
    if (s1_nan1_q || s1_nan2_q) begin
      res_d = 1'b0;
      case (s1_op_q)
        FOP_FLT, FOP_FLE: nv_d = 1'b1;
        FOP_FEQ:          nv_d = s1_snan1_q | s1_snan2_q;
        default:          nv_d = 1'b0;
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= 1'b0;
      out_tag_q   <= '0;
`ifdef FCMP_NAN_EN
      out_nv_q    <= 1'b0;
`endif
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      out_y_q     <= res_d;
      out_tag_q   <= s1_tag_q;
`ifdef FCMP_NAN_EN
      out_nv_q    <= nv_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = {31'd0, out_y_q};
  assign out_tag   = out_tag_q;
`ifdef FCMP_NAN_EN
  assign out_nv    = out_nv_q;
`else
  assign out_nv    = 1'b0;
`endif

endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe: vector table, scoreboard queue, and
// hand-built latency/backpressure/throughput/reset sequences.
module tb_fcmp_pipe;

  localparam int TAG_W = 5;
`ifdef FCMP_NAN_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        y_plain;
    logic        y_nan;
    logic        nv_nan;
  } vec_t;

  typedef struct {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    logic             nv;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_x1;
  logic [31:0]      in_x2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic             out_nv;

  logic drv_y;
  logic drv_nv;

  vec_t vecs[18];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fcmp_pipe #(.TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_x1    (in_x1),
    .in_x2    (in_x2),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_tag  (out_tag),
    .out_nv   (out_nv)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor on the falling edge: handshakes seen here complete on the next rising edge.
  logic held_pend = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      held_pend = 1'b0;
    end else begin
      if (held_pend) begin
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_out_y", out_y, held.y);
        check("stall_out_tag", 32'(out_tag), 32'(held.tag));
        check("stall_out_nv", 32'(out_nv), 32'(held.nv));
      end
      held_pend = out_valid && !out_ready;
      held      = '{out_y, out_tag, out_nv};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_y", out_y, e.y);
          check("out_tag", 32'(out_tag), 32'(e.tag));
          check("out_nv", 32'(out_nv), 32'(e.nv));
        end
      end
      if (in_valid && in_ready) exp_q.push_back('{32'(drv_y), in_tag, drv_nv});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int i, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_op    = vecs[i].op;
    in_x1    = vecs[i].x1;
    in_x2    = vecs[i].x2;
    in_tag   = tag;
    drv_y    = NAN_EN ? vecs[i].y_nan : vecs[i].y_plain;
    drv_nv   = NAN_EN ? vecs[i].nv_nan : 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && k < 50) begin
      step();
      k++;
    end
    check("drain_done", 32'(k < 50), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   idx;
    int   k;
    int   stale;
    int   run;
    int   max_run;
    logic acc;
    int   bp[4];

    //                op     x1            x2            plain nan  nv
    vecs[0]  = '{2'b01, 32'hBF80_0000, 32'h3F80_0000, 1'b1, 1'b1, 1'b0}; // -1 < 1
    vecs[1]  = '{2'b01, 32'h3F80_0000, 32'hBF80_0000, 1'b0, 1'b0, 1'b0}; // 1 < -1
    vecs[2]  = '{2'b00, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0}; // -0 == +0
    vecs[3]  = '{2'b01, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0}; // -0 < +0
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0}; // -0 <= +0
    vecs[5]  = '{2'b10, 32'hC000_0000, 32'hBF80_0000, 1'b1, 1'b1, 1'b0}; // -2 <= -1
    vecs[6]  = '{2'b01, 32'hBF80_0000, 32'hC000_0000, 1'b0, 1'b0, 1'b0}; // -1 < -2
    vecs[7]  = '{2'b00, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 1'b1, 1'b0}; // 1 == 1
    vecs[8]  = '{2'b10, 32'h7F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0}; // +inf <= 1
    vecs[9]  = '{2'b01, 32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0}; // -inf < -0
    vecs[10] = '{2'b11, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0}; // reserved op
    vecs[11] = '{2'b01, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0}; // denorm < 0
    vecs[12] = '{2'b01, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0}; // 0 < denorm
    vecs[13] = '{2'b01, 32'h8000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0}; // -denorm < 0
    vecs[14] = '{2'b01, 32'h7FC0_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b1}; // qNaN < 1
    vecs[15] = '{2'b00, 32'h7FC0_0000, 32'h7FC0_0000, 1'b1, 1'b0, 1'b0}; // qNaN == qNaN
    vecs[16] = '{2'b00, 32'h7F80_0001, 32'h7F80_0001, 1'b1, 1'b0, 1'b1}; // sNaN == sNaN
    vecs[17] = '{2'b10, 32'h3F80_0000, 32'hFFC0_0000, 1'b0, 1'b0, 1'b1}; // 1 <= -qNaN

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_x1     = 32'd0;
    in_x2     = 32'd0;
    in_tag    = '0;
    out_ready = 1'b0;
    drv_y     = 1'b0;
    drv_nv    = 1'b0;
    step();
    step();

    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_y", out_y, 32'd0);
    check("reset_out_tag", 32'(out_tag), 32'd0);
    check("reset_out_nv", 32'(out_nv), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Latency: presented in cycle c, visible on out_* in cycle c+2.
    rst       = 1'b0;
    out_ready = 1'b1;
    present(0, 5'd1);
    step();
    idle();
    check("lat_not_early", 32'(out_valid), 32'd0);
    step();
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_y", out_y, 32'd1);
    drain();

    present(1, 5'd2);
    step();
    idle();
    step();
    check("swap_out_y", out_y, 32'd0);
    drain();

    // Throughput: 8 back-to-back table vectors, no backpressure.
    run     = 0;
    max_run = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        present(c, TAG_W'(c + 3));
        check("tput_in_ready", 32'(in_ready), 32'd1);
      end else begin
        idle();
      end
      if (out_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      step();
    end
    idle();
    check("tput_run_len", 32'(max_run), 32'd8);
    drain();

    // Remaining vectors under random backpressure.
    idx = 8;
    k   = 0;
    while (idx < 18 && k < 300) begin
      present(idx, TAG_W'(idx));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = in_ready;
      step();
      if (acc) idx++;
      k++;
    end
    check("rand_feed_done", 32'(idx), 32'd18);
    idle();
    drain();

    // Backpressure: four FLE ops, tags 1..4, out_ready low for 5 cycles.
    bp        = '{4, 5, 8, 17};
    out_ready = 1'b0;
    idx       = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 4) present(bp[idx], TAG_W'(idx + 1));
      else idle();
      #1;
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    check("bp_accepts", 32'(idx), 32'd2);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    k = 0;
    while (idx < 4 && k < 20) begin
      present(bp[idx], TAG_W'(idx + 1));
      #1;
      acc = in_ready;
      step();
      if (acc) idx++;
      k++;
    end
    check("bp_feed_done", 32'(idx), 32'd4);
    idle();
    drain();

    // Reset with two ops in flight: both are discarded.
    out_ready = 1'b1;
    present(0, 5'd9);
    step();
    present(7, 5'd10);
    step();
    rst = 1'b1;
    idle();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst   = 1'b0;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (out_valid) stale++;
    end
    check("rst_no_stale", 32'(stale), 32'd0);
    check("rst_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
